// File: rtl/writeback_arbiter_pkg.sv
// Shared types for the ROB writeback arbiter: result payload and source encoding.
// Pure declarations, no logic.
// Source order M, U, L doubles as the grant priority and port-assignment order.
package writeback_arbiter_pkg;

  typedef struct packed {
    logic [3:0]  ageTag;
    logic [31:0] instructionResult;
    logic        valid;
  } InputInstruction_;

  typedef enum logic [1:0] {
    SOURCE_MEMORY = 2'd0,
    SOURCE_UPPER  = 2'd1,
    SOURCE_LOWER  = 2'd2
  } WritebackSource_;

  localparam int NUM_SOURCES = 3;
  localparam int SRC_M = int'(SOURCE_MEMORY);
  localparam int SRC_U = int'(SOURCE_UPPER);
  localparam int SRC_L = int'(SOURCE_LOWER);

endpackage

// File: rtl/writeback_arbiter_result_hold_slot.sv
// One-entry result holding slot with capture, drain on grant and flush.
// Latency: a captured result is visible on held the cycle after capture.
// Backpressure: ready while empty, or while being drained and not stalled.
module result_hold_slot
  import writeback_arbiter_pkg::*;
(
  input  logic             clock,
  input  logic             resetN,
  input  logic             flush,
  input  logic             stall,
  input  logic             granted,
  input  InputInstruction_ inResult,
  output logic             inReady,
  output logic             full,
  output InputInstruction_ held
);

  logic             full_q, full_d;
  InputInstruction_ held_q, held_d;
  logic             capture;

  // Ready never looks at inResult.valid, so no combinational loop back to producers.
  always_comb begin
    inReady = !flush && (!full_q || (granted && !stall));
    capture = inResult.valid && inReady;
  end

  // Next state: flush wins, then capture (refills a draining slot), then drain.
  always_comb begin
    full_d = full_q;
    held_d = held_q;
    if (flush) begin
      full_d = 1'b0;
    end else if (capture) begin
      full_d = 1'b1;
      held_d = inResult;
    end else if (granted) begin
      full_d = 1'b0;
    end
  end

  // Slot registers.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      full_q <= 1'b0;
      held_q <= '0;
    end else begin
      full_q <= full_d;
      held_q <= held_d;
    end
  end

  assign full = full_q;
  assign held = held_q;

endmodule

// File: rtl/writeback_arbiter.sv
// Drains up to two of three held results (memory, upper, lower) onto two ROB write ports.
// Latency: capture at edge N, ROB port valid during cycle N+1; ports are combinational.
// Backpressure: per-source ready; robStall freezes all slots, flush empties them.
module writeback_arbiter
  import writeback_arbiter_pkg::*;
(
  input  logic             clock,
  input  logic             resetN,
  input  logic             flush,
  input  logic             robStall,
  input  InputInstruction_ upperResult,
  output logic             upperReady,
  input  InputInstruction_ lowerResult,
  output logic             lowerReady,
  input  InputInstruction_ memoryResult,
  output logic             memoryReady,
  output InputInstruction_ robPort0,
  output InputInstruction_ robPort1
);

  logic [NUM_SOURCES-1:0] full_w;
  logic [NUM_SOURCES-1:0] grant_w;
  logic [NUM_SOURCES-1:0] ready_w;
  InputInstruction_       held_w [NUM_SOURCES];
  InputInstruction_       in_w   [NUM_SOURCES];
  logic                   favorLower_q, favorLower_d;

  assign in_w[SRC_M] = memoryResult;
  assign in_w[SRC_U] = upperResult;
  assign in_w[SRC_L] = lowerResult;

  for (genvar s = 0; s < NUM_SOURCES; s++) begin : g_slot
    result_hold_slot u_slot (
      .clock    (clock),
      .resetN   (resetN),
      .flush    (flush),
      .stall    (robStall),
      .granted  (grant_w[s]),
      .inResult (in_w[s]),
      .inReady  (ready_w[s]),
      .full     (full_w[s]),
      .held     (held_w[s])
    );
  end

  assign memoryReady = ready_w[SRC_M];
  assign upperReady  = ready_w[SRC_U];
  assign lowerReady  = ready_w[SRC_L];

  // Grant: memory always wins; on a three-way conflict upper/lower alternate via favorLower.
  always_comb begin
    grant_w      = '0;
    favorLower_d = favorLower_q;
    if (flush) begin
      favorLower_d = 1'b0;
    end else if (!robStall) begin
      if (&full_w) begin
        grant_w[SRC_M] = 1'b1;
        grant_w[SRC_U] = !favorLower_q;
        grant_w[SRC_L] = favorLower_q;
        favorLower_d   = !favorLower_q;
      end else begin
        grant_w = full_w;
      end
    end
  end

  // Port steering: first granted source in M, U, L order to port0, second to port1.
  always_comb begin
    logic taken0;
    robPort0 = '0;
    robPort1 = '0;
    taken0   = 1'b0;
    for (int s = 0; s < NUM_SOURCES; s++) begin
      if (grant_w[s]) begin
        if (!taken0) begin
          robPort0 = held_w[s];
          taken0   = 1'b1;
        end else begin
          robPort1 = held_w[s];
        end
      end
    end
  end

  // Fairness bit between the two execute slots.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      favorLower_q <= 1'b0;
    end else begin
      favorLower_q <= favorLower_d;
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;
  import writeback_arbiter_pkg::*;

  logic             clock = 1'b0;
  logic             resetN;
  logic             flush;
  logic             robStall;
  InputInstruction_ upperResult, lowerResult, memoryResult;
  logic             upperReady, lowerReady, memoryReady;
  InputInstruction_ robPort0, robPort1;

  writeback_arbiter dut (
    .clock        (clock),
    .resetN       (resetN),
    .flush        (flush),
    .robStall     (robStall),
    .upperResult  (upperResult),
    .upperReady   (upperReady),
    .lowerResult  (lowerResult),
    .lowerReady   (lowerReady),
    .memoryResult (memoryResult),
    .memoryReady  (memoryReady),
    .robPort0     (robPort0),
    .robPort1     (robPort1)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]       rdy;   // {memory, upper, lower}
    InputInstruction_ p0;
    InputInstruction_ p1;
  } cycle_exp_t;

  cycle_exp_t exp_q[$];

  // Reference model: one optional pending result per source (index 0=M, 1=U, 2=L).
  logic             m_full [3];
  InputInstruction_ m_dat  [3];
  logic             m_favor;

  task automatic check37(input string name, input InputInstruction_ got, input InputInstruction_ want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic check3(input string name, input logic [2:0] got, input logic [2:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%b want=%b", name, got, want);
    end
  endtask

  function automatic InputInstruction_ mk(input logic [3:0] tag, input logic [31:0] d, input logic v);
    InputInstruction_ r;
    r.ageTag = tag;
    r.instructionResult = d;
    r.valid = v;
    return r;
  endfunction

  function automatic InputInstruction_ rnd(input logic v);
    return mk(4'($urandom), $urandom, v);
  endfunction

  task automatic model_clear();
    for (int s = 0; s < 3; s++) begin
      m_full[s] = 1'b0;
      m_dat[s]  = '0;
    end
    m_favor = 1'b0;
  endtask

  // Drive one cycle, predict its outputs from the model, then advance the model past the edge.
  task automatic step(input InputInstruction_ m, input InputInstruction_ u, input InputInstruction_ l,
                      input logic st, input logic fl);
    InputInstruction_ ins[3];
    logic             gr[3];
    int               pending[$];
    int               winners[$];
    cycle_exp_t       e;
    @(negedge clock);
    memoryResult = m;
    upperResult  = u;
    lowerResult  = l;
    robStall     = st;
    flush        = fl;
    #1;
    ins[0] = m; ins[1] = u; ins[2] = l;
    for (int s = 0; s < 3; s++) begin
      gr[s] = 1'b0;
      if (m_full[s]) pending.push_back(s);
    end
    if (!fl && !st) begin
      if (pending.size() == 3) begin
        gr[0] = 1'b1;
        if (m_favor) gr[2] = 1'b1; else gr[1] = 1'b1;
      end else begin
        foreach (pending[i]) gr[pending[i]] = 1'b1;
      end
    end
    for (int s = 0; s < 3; s++) if (gr[s]) winners.push_back(s);
    e.p0 = '0;
    e.p1 = '0;
    if (winners.size() > 0) e.p0 = m_dat[winners[0]];
    if (winners.size() > 1) e.p1 = m_dat[winners[1]];
    for (int s = 0; s < 3; s++) e.rdy[2-s] = !fl && (!m_full[s] || gr[s]);
    exp_q.push_back(e);
    // state after the edge
    if (fl) m_favor = 1'b0;
    else if (gr[1] && pending.size() == 3) m_favor = 1'b1;
    else if (gr[2] && pending.size() == 3) m_favor = 1'b0;
    for (int s = 0; s < 3; s++) begin
      if (fl) m_full[s] = 1'b0;
      else if (ins[s].valid && e.rdy[2-s]) begin
        m_full[s] = 1'b1;
        m_dat[s]  = ins[s];
      end else if (gr[s]) m_full[s] = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, '0, 1'b0, 1'b0);
  endtask

  // Monitor: each cycle, after the driver has settled inputs, compare against the oldest prediction.
  initial begin
    cycle_exp_t e;
    forever begin
      @(negedge clock);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check3("ready", {memoryReady, upperReady, lowerReady}, e.rdy);
        check37("port0", robPort0, e.p0);
        check37("port1", robPort1, e.p1);
      end
    end
  end

  initial begin
    logic [3:0] t;
    resetN = 1'b0;
    flush = 1'b0;
    robStall = 1'b0;
    upperResult = '0;
    lowerResult = '0;
    memoryResult = '0;
    model_clear();
    #12;
    check37("reset_port0", robPort0, '0);
    check37("reset_port1", robPort1, '0);
    check3("reset_ready", {memoryReady, upperReady, lowerReady}, 3'b111);
    @(negedge clock);
    resetN = 1'b1;

    // Single source with a fixed payload.
    step('0, mk(4'h3, 32'hDEADBEEF, 1'b1), '0, 1'b0, 1'b0);
    step('0, '0, '0, 1'b0, 1'b0);
    check37("single_port0", robPort0, mk(4'h3, 32'hDEADBEEF, 1'b1));
    idle(1);

    // Three-way conflict, new tags every cycle.
    for (int i = 0; i < 5; i++) begin
      t = 4'(i);
      step(mk(t, 32'h1000 + i, 1'b1), mk(t, 32'h2000 + i, 1'b1), mk(t, 32'h3000 + i, 1'b1), 1'b0, 1'b0);
    end
    idle(3);

    // Stall with U and L held.
    step('0, rnd(1'b1), rnd(1'b1), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step('0, '0, '0, 1'b1, 1'b0);
    idle(2);

    // Flush with M and U held, then a conflict.
    step(rnd(1'b1), rnd(1'b1), '0, 1'b0, 1'b0);
    step(rnd(1'b1), rnd(1'b1), rnd(1'b1), 1'b0, 1'b1);
    idle(2);
    for (int i = 0; i < 3; i++) step(rnd(1'b1), rnd(1'b1), rnd(1'b1), 1'b0, 1'b0);
    idle(3);

    // Drain-and-refill on the upper slot.
    for (int i = 0; i < 8; i++) step('0, mk(4'(i), $urandom, 1'b1), '0, 1'b0, 1'b0);
    idle(2);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step(rnd($urandom_range(0, 9) < 7), rnd($urandom_range(0, 9) < 7), rnd($urandom_range(0, 9) < 7),
           $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 5);
    end

    // Asynchronous reset with every slot full.
    for (int i = 0; i < 2; i++) step(rnd(1'b1), rnd(1'b1), rnd(1'b1), 1'b1, 1'b0);
    @(posedge clock);
    #2;
    resetN = 1'b0;
    memoryResult = '0;
    upperResult = '0;
    lowerResult = '0;
    robStall = 1'b0;
    model_clear();
    #1;
    check37("async_port0", robPort0, '0);
    check37("async_port1", robPort1, '0);
    check3("async_ready", {memoryReady, upperReady, lowerReady}, 3'b111);
    #1;
    resetN = 1'b1;
    idle(4);
    step(rnd(1'b1), '0, '0, 1'b0, 1'b0);
    idle(2);

    @(negedge clock);
    #3;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_queue got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Shares the two reorder-buffer result write ports between three result producers: the upper execute slot, the lower execute slot and the memory queue load-return path. Each producer has a one-entry holding slot with a valid/ready handshake. Every cycle the arbiter drains up to two held results onto the ROB ports; memory returns have fixed priority and the two execute slots alternate on conflict. It sits between execute/memory and the ROB, and carries `InputInstruction_` payloads unchanged.

## Interface
- Parameters: none; all widths are fixed by the `Payloads` package (`InputInstruction_` = 4-bit `ageTag`, 32-bit `instructionResult`, 1-bit `valid`).
- `clock`  in  1  single clock, rising edge.
- `resetN`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous pipeline flush; discards all held results.
- `robStall`  in  1  the ROB cannot accept results this cycle.
- `upperResult`  in  `InputInstruction_`  upper slot result; offered when `.valid`=1.
- `upperReady`  out  1  the upper result is captured this cycle when `upperResult.valid` & `upperReady`.
- `lowerResult`  in  `InputInstruction_`  lower slot result.
- `lowerReady`  out  1  handshake for the lower slot.
- `memoryResult`  in  `InputInstruction_`  load-return result from the memory queue.
- `memoryReady`  out  1  handshake for the memory path.
- `robPort0`  out  `InputInstruction_`  ROB write port 0.
- `robPort1`  out  `InputInstruction_`  ROB write port 1.

## Operation
- Holding slot per source (M, U, L): `held` (`InputInstruction_`) and `full`.
  - Capture when input `.valid` & ready. `held` takes the input and `full` sets.
- Candidate set = sources with `full`=1.
- Grant, when `robStall`=0 and `flush`=0:
  - 0–2 candidates: all are granted.
  - 3 candidates: M is always granted, plus U if `favorLower`=0, otherwise L.
  - Port assignment: port0 gets the first granted source in the order M, U, L; port1 gets the second.
  - Unused ports drive all-zero with `.valid`=0.
- A granted slot clears `full` at the clock edge, unless the same source captures a new result in the same cycle, in which case the slot refills.
- Ready:
  - `xReady` = !`flush` & (!`full_x` | `granted_x`). This allows back-to-back capture at full throughput.
  - With `robStall`=1, `xReady` = !`flush` & !`full_x`.
- `favorLower` flip-flop:
  - Updated only on a 3-candidate grant: set to 1 if U won, cleared if L won.
  - Otherwise it holds.
  - Guarantees neither U nor L waits more than one conflict cycle behind the other.
- `flush`=1:
  - Clears all `full` bits and clears `favorLower`.
  - All ready outputs = 0, no grants, both ports invalid.
  - `flush` overrides `robStall`.
- `robStall`=1:
  - No grants; ports invalid.
  - Held entries and `favorLower` are unchanged.
- Inputs with `.valid`=0 are never captured, regardless of ready.
- Payloads pass through bit-exact; no tag inspection or ordering by age.

## Timing
- Reset (`resetN`=0, asynchronous):
  - All `full`=0 and `favorLower`=0.
  - `robPort0`/`robPort1` all-zero with `.valid`=0.
  - `upperReady`/`lowerReady`/`memoryReady`=1 (since `flush` is low).
- Latency: a result captured at edge N appears on a ROB port during cycle N+1, the earliest case.
- ROB ports are driven combinationally from the holding registers.
- Ready is combinational from `full`, the grant result, `flush` and `robStall`; it does not depend on the input `.valid`.
- Throughput: 2 results/cycle sustained; 3 continuously-valid sources give M one per cycle and U, L one every other cycle each.
- Reset asserted mid-operation discards held results immediately; nothing is emitted after release until a new capture.

## Structure
- Add a `WritebackSource_` enum (`SOURCE_MEMORY`, `SOURCE_UPPER`, `SOURCE_LOWER`) to `Enumerations` for grant encoding and bench use.
- Reuse `InputInstruction_` from `Payloads`; no new payload struct.
- Sub-module `result_hold_slot`, instantiated 3×:
  - Holds one entry with capture/drain/flush.
  - Outputs `full`, `held` and ready given `granted` and `stall`.

## Test plan
- Single source: after reset, one cycle of `upperResult` = {tag 4'h3, 32'hDEADBEEF, valid} → `robPort0` = {3, DEADBEEF, 1} in the next cycle, `robPort1.valid`=0, `upperReady` stays 1.
- Three-way conflict: M (tag 1), U (tag 2) and L (tag 3) are held continuously valid with new tags each cycle.
  - Cycle 1 → port0=M, port1=U.
  - Cycle 2 → M, L.
  - Cycle 3 → M, U.
  - `lowerReady`=0 in cycle 1 and `upperReady`=0 in cycle 2.
- Stall: U and L are held, then `robStall`=1 for 3 cycles → ports invalid, `upperReady`=`lowerReady`=0, `memoryReady`=1; on release, U→port0 and L→port1 in the same cycle.
- Flush: M and U are held, then `flush` pulses for 1 cycle → all readies 0 in that cycle, no emission then or afterwards; `favorLower` is cleared (the next 3-way conflict grants U).
- Drain-and-refill: U is offered valid every cycle with tags 0..7 and there is no conflict → port0 carries tags 0..7 on consecutive cycles with no bubble; `upperReady` is never 0.
- Async reset mid-traffic: `resetN` drops with all slots full → ports go invalid immediately without a clock edge; after release, readies are 1 and nothing is emitted until a new capture.
